// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the multiply/divide HI/LO unit.
// Holds the 5-bit HILO operation codes (also decoded by the D-stage hazard
// logic), the unit's FSM state encoding and the accumulate mode of the
// multiply path, plus small decode helpers.
package md_unit_pkg;

  typedef enum logic [4:0] {
    HILO_NONE  = 5'd0,
    HILO_MULT  = 5'd1,
    HILO_MULTU = 5'd2,
    HILO_DIV   = 5'd3,
    HILO_DIVU  = 5'd4,
    HILO_MADD  = 5'd5,
    HILO_MADDU = 5'd6,
    HILO_MSUB  = 5'd7,
    HILO_MSUBU = 5'd8,
    HILO_MFHI  = 5'd9,
    HILO_MFLO  = 5'd10,
    HILO_MTHI  = 5'd11,
    HILO_MTLO  = 5'd12
  } hilo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } md_state_e;

  // How the registered product is folded into {HI,LO} at commit.
  typedef enum logic [1:0] {
    ACC_SET,
    ACC_ADD,
    ACC_SUB
  } acc_mode_e;

  function automatic logic is_mul(hilo_op_e op);
    return op inside {HILO_MULT, HILO_MULTU, HILO_MADD, HILO_MADDU,
                      HILO_MSUB, HILO_MSUBU};
  endfunction

  function automatic logic is_div(hilo_op_e op);
    return op inside {HILO_DIV, HILO_DIVU};
  endfunction

  // The sign letter of MADD/MSUB only selects product signedness.
  function automatic logic mul_signed(hilo_op_e op);
    return op inside {HILO_MULT, HILO_MADD, HILO_MSUB};
  endfunction

  function automatic acc_mode_e acc_mode(hilo_op_e op);
    acc_mode_e m;
    case (op)
      HILO_MADD, HILO_MADDU: m = ACC_ADD;
      HILO_MSUB, HILO_MSUBU: m = ACC_SUB;
      default:               m = ACC_SET;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage to HI/LO unit bus.
//   Req      - interrupt/exception taken this cycle (blocks issue/write)
//   A, B     - rs/dividend/MT source and rt/divisor operands
//   HILOOp   - operation code
//   HILOout  - HI for MFHI, LO for MFLO, 0 otherwise (combinational)
//   HILObusy - multi-cycle op issuing or in flight
//   HILOdone - one-cycle pulse in the cycle HI/LO commit
// master drives the request side (pipeline), slave is the md_unit.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic                  Req;
  logic [WIDTH-1:0]      A;
  logic [WIDTH-1:0]      B;
  md_unit_pkg::hilo_op_e HILOOp;
  logic [WIDTH-1:0]      HILOout;
  logic                  HILObusy;
  logic                  HILOdone;

  modport master (
    output Req, A, B, HILOOp,
    input  HILOout, HILObusy, HILOdone
  );

  modport slave (
    input  Req, A, B, HILOOp,
    output HILOout, HILObusy, HILOdone
  );

endinterface

// File: rtl/md_unit_div_iter.sv
// md_div_iter: unsigned restoring divider, one quotient bit per cycle.
//   clk, rst  - clock, asynchronous active-low reset
//   start     - load operands; the first iteration is performed on load
//   dividend  - unsigned dividend
//   divisor   - unsigned divisor
//   quotient  - quotient (valid once valid is high)
//   remainder - remainder (valid once valid is high)
//   valid     - result complete; held until the next start
// A result is available WIDTH cycles after the start cycle.
module md_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int unsigned IW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [IW-1:0]    left_q;
  logic             run_q;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. Returns {rem, quo}.
  // The partial remainder stays below the divisor, so the shifted value is
  // below twice the divisor and bit WIDTH of the difference is a true sign.
  function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] rem,
                                              input logic [WIDTH-1:0] quo,
                                              input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    sh   = {rem, quo[WIDTH-1]};
    diff = sh - {1'b0, dvs};
    if (!diff[WIDTH]) return {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    else              return {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      left_q <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      {rem_q, quo_q} <= step('0, dividend, divisor);
      dvs_q          <= divisor;
      left_q         <= IW'(WIDTH - 1);
      run_q          <= 1'b1;
    end else if (run_q && left_q != '0) begin
      {rem_q, quo_q} <= step(rem_q, quo_q, dvs_q);
      left_q         <= left_q - IW'(1);
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign valid     = run_q && (left_q == '0);

endmodule

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with HI/LO state for the E stage.
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   bus      - md_unit_if slave: Req, A, B, HILOOp in; HILOout, HILObusy,
//              HILOdone out
// Multiply-class ops register the full product at issue and commit after
// MUL_CYCLES; divides run the bit-serial divider and commit after
// DIV_CYCLES. MTHI/MTLO write in a single cycle.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic     clk,
  input  logic     rst,
  md_unit_if.slave bus
);

  if (MUL_CYCLES < 1) begin : g_bad_mul
    $error("md_unit: MUL_CYCLES must be at least 1");
  end
  if (DIV_CYCLES < WIDTH) begin : g_bad_div
    $error("md_unit: DIV_CYCLES must be at least WIDTH");
  end

  localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]    MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0]    DIV_LOAD = CW'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  hilo_op_e  op;
  md_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic issue, issue_mul, issue_div, commit, busy;

  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] prod_q;
  acc_mode_e          acc_q;
  logic [WIDTH-1:0]   dvd_q;
  logic               q_neg_q, r_neg_q, dz_q, ovf_q;

  logic [2*WIDTH-1:0] ext_a, ext_b, product;
  logic               div_sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   div_quo, div_rem;
  logic               div_valid;
  logic [WIDTH-1:0]   div_lo, div_hi;
  logic [2*WIDTH-1:0] hilo_next;

  assign op        = bus.HILOOp;
  assign issue     = (state_q == ST_IDLE) && !bus.Req;
  assign issue_mul = issue && is_mul(op);
  assign issue_div = issue && is_div(op);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue_mul) begin
          state_d = ST_MUL;
          cnt_d   = MUL_LOAD;
          busy    = 1'b1;
        end else if (issue_div) begin
          state_d = ST_DIV;
          cnt_d   = DIV_LOAD;
          busy    = 1'b1;
        end
      end
      ST_MUL, ST_DIV: begin
        busy  = 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------- operand preparation ----------------
  always_comb begin
    ext_a = mul_signed(op) ? {{WIDTH{bus.A[WIDTH-1]}}, bus.A} : {{WIDTH{1'b0}}, bus.A};
    ext_b = mul_signed(op) ? {{WIDTH{bus.B[WIDTH-1]}}, bus.B} : {{WIDTH{1'b0}}, bus.B};
    // Product of the extended operands, kept mod 2^(2*WIDTH).
    product = ext_a * ext_b;
    div_sgn = (op == HILO_DIV);
    a_neg   = div_sgn && bus.A[WIDTH-1];
    b_neg   = div_sgn && bus.B[WIDTH-1];
    abs_a   = a_neg ? -bus.A : bus.A;
    abs_b   = b_neg ? -bus.B : bus.B;
  end

  md_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (issue_div),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q  <= '0;
      acc_q   <= ACC_SET;
      dvd_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (issue_mul) begin
      prod_q <= product;
      acc_q  <= acc_mode(op);
    end else if (issue_div) begin
      dvd_q   <= bus.A;
      q_neg_q <= a_neg ^ b_neg;
      r_neg_q <= a_neg;
      dz_q    <= (bus.B == '0);
      ovf_q   <= div_sgn && (bus.A == MIN_NEG) && (bus.B == '1);
    end
  end

  // ---------------- commit values ----------------
  always_comb begin
    div_lo = div_quo;
    div_hi = div_rem;
    if (dz_q) begin
      div_lo = '1;
      div_hi = dvd_q;
    end else if (ovf_q) begin
      div_lo = dvd_q;
      div_hi = '0;
    end else begin
      if (q_neg_q) div_lo = -div_quo;
      if (r_neg_q) div_hi = -div_rem;
    end
    case (acc_q)
      ACC_ADD: hilo_next = {hi_q, lo_q} + prod_q;
      ACC_SUB: hilo_next = {hi_q, lo_q} - prod_q;
      default: hilo_next = prod_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      if (state_q == ST_MUL) begin
        {hi_q, lo_q} <= hilo_next;
      end else if (div_valid) begin
        hi_q <= div_hi;
        lo_q <= div_lo;
      end
    end else if (issue) begin
      if (op == HILO_MTHI) hi_q <= bus.A;
      if (op == HILO_MTLO) lo_q <= bus.A;
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    case (op)
      HILO_MFHI: bus.HILOout = hi_q;
      HILO_MFLO: bus.HILOout = lo_q;
      default:   bus.HILOout = '0;
    endcase
  end

  assign bus.HILObusy = busy;
  assign bus.HILOdone = commit;

endmodule
